// File: rtl/square_judge_seq_if.sv
// Handshake bundle between the square-judge sequencer (master) and the judge block (slave).
interface square_judge_seq_if #(
  parameter int unsigned WIDTH_W = 18
);
  logic               jdg_start;
  logic               jdg_is_square;
  logic [WIDTH_W-1:0] jdg_min_width;
  logic               jdg_dready;

  modport master (
    output jdg_start,
    input  jdg_is_square,
    input  jdg_min_width,
    input  jdg_dready
  );

  modport slave (
    input  jdg_start,
    output jdg_is_square,
    output jdg_min_width,
    output jdg_dready
  );
endinterface

// File: rtl/square_judge_seq.sv
// Runs ROUNDS judge windows per trigger, majority-votes the square decisions and keeps the min valid width.
// Optional SQJ_AUTO_RERUN_EN: back-to-back runs until abort or reset.
module square_judge_seq #(
  parameter int unsigned WIDTH_W = 18,
  parameter int unsigned ROUNDS  = 4,
  parameter int unsigned RND_W   = 4,
  parameter int unsigned VOTE_TH = 3,
  parameter int unsigned GAP_CYC = 16,
  parameter int unsigned TMO_CYC = 8192,
  parameter int unsigned TMO_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       trig,
  input  logic                       abort,
  square_judge_seq_if.master         jdg,
  output logic                       busy,
  output logic                       done,
  output logic                       is_square,
  output logic [RND_W-1:0]           vote_cnt,
  output logic [WIDTH_W-1:0]         width_min,
  output logic                       timeout_err
);

  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {IDLE, START, WAIT, GAP, DONE} state_t;

  state_t             state;
  logic [RND_W-1:0]   acc_vote;
  logic [WIDTH_W-1:0] acc_wmin;
  logic [RND_W-1:0]   rnd;
  logic [GAP_W-1:0]   gap_cnt;
  logic [TMO_W-1:0]   tmo_cnt;

  logic tmo_hit;
  logic last_rnd;
  logic w_valid;

  always_comb begin
    tmo_hit  = (tmo_cnt == TMO_W'(TMO_CYC - 1));
    last_rnd = (rnd == RND_W'(ROUNDS - 1));
    w_valid  = (jdg.jdg_min_width != '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      jdg.jdg_start <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      is_square     <= 1'b0;
      vote_cnt      <= '0;
      width_min     <= '1;
      timeout_err   <= 1'b0;
      acc_vote      <= '0;
      acc_wmin      <= '1;
      rnd           <= '0;
      gap_cnt       <= '0;
      tmo_cnt       <= '0;
    end else begin
      done          <= 1'b0;
      jdg.jdg_start <= 1'b0;
      // abort outranks everything, including a same-cycle judge result
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (trig && !abort) begin
              state         <= START;
              jdg.jdg_start <= 1'b1;
              busy          <= 1'b1;
              acc_vote      <= '0;
              acc_wmin      <= '1;
              rnd           <= '0;
              timeout_err   <= 1'b0;
            end
          end
          START: begin
            tmo_cnt <= '0;
            state   <= WAIT;
          end
          WAIT: begin
            if (jdg.jdg_dready || tmo_hit) begin
              if (jdg.jdg_dready) begin
                acc_vote <= acc_vote + {{(RND_W-1){1'b0}}, jdg.jdg_is_square};
                if (w_valid && jdg.jdg_min_width < acc_wmin)
                  acc_wmin <= jdg.jdg_min_width;
              end else begin
                timeout_err <= 1'b1;
              end
              rnd <= rnd + RND_W'(1);
              if (last_rnd) begin
                state <= DONE;
              end else if (GAP_CYC == 0) begin
                state         <= START;
                jdg.jdg_start <= 1'b1;
              end else begin
                state   <= GAP;
                gap_cnt <= '0;
              end
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
          GAP: begin
            if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
              state         <= START;
              jdg.jdg_start <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          DONE: begin
            is_square <= (acc_vote >= RND_W'(VOTE_TH));
            vote_cnt  <= acc_vote;
            width_min <= acc_wmin;
            done      <= 1'b1;
`ifdef SQJ_AUTO_RERUN_EN
            acc_vote    <= '0;
            acc_wmin    <= '1;
            rnd         <= '0;
            timeout_err <= 1'b0;
            if (GAP_CYC == 0) begin
              state         <= START;
              jdg.jdg_start <= 1'b1;
            end else begin
              state   <= GAP;
              gap_cnt <= '0;
            end
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_square_judge_seq.sv
// Scoreboard bench for square_judge_seq: a behavioural judge answers each start, a monitor checks every done.
module tb_square_judge_seq;

  localparam int unsigned WIDTH_W = 18;
  localparam int unsigned RND_W   = 4;
  localparam logic [WIDTH_W-1:0] W_NONE = '1;

  typedef struct {
    logic               sq;
    logic [RND_W-1:0]   vote;
    logic [WIDTH_W-1:0] wmin;
    logic               tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trig = 1'b0;
  logic abort = 1'b0;
  logic busy, done, is_square, timeout_err;
  logic [RND_W-1:0]   vote_cnt;
  logic [WIDTH_W-1:0] width_min;

  logic               judge_dready = 1'b0;
  logic               inject_dready = 1'b0;
  logic               judge_sq = 1'b0;
  logic [WIDTH_W-1:0] judge_w = '0;

  square_judge_seq_if #(.WIDTH_W(WIDTH_W)) jif ();
  assign jif.jdg_dready    = judge_dready | inject_dready;
  assign jif.jdg_is_square = judge_sq;
  assign jif.jdg_min_width = judge_w;

  square_judge_seq #(
    .WIDTH_W(WIDTH_W), .ROUNDS(4), .RND_W(RND_W), .VOTE_TH(3),
    .GAP_CYC(16), .TMO_CYC(8192), .TMO_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .abort(abort), .jdg(jif),
    .busy(busy), .done(done), .is_square(is_square), .vote_cnt(vote_cnt),
    .width_min(width_min), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int n_done = 0;
  exp_t q[$];

  logic [3:0]         tab_sq;
  logic [3:0]         tab_sil;
  logic [WIDTH_W-1:0] tab_w [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Judge model: answers 100 cycles after each start unless the window is marked silent.
  initial begin : judge
    int cyc = 0, cd = 0, win = 0, rsp = 0, last_rdy = 0;
    forever begin
      @(negedge clk);
      cyc++;
      judge_dready = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          judge_dready = 1'b1;
          judge_sq     = tab_sq[rsp];
          judge_w      = tab_w[rsp];
          last_rdy     = cyc;
        end
      end
      if (rst_n && jif.jdg_start) begin
        if (win % 4 != 0)
          chk("gap_after_dready_ge17", 32'(cyc - last_rdy >= 17), 32'd1);
        n_start++;
        rsp = win % 4;
        win++;
        if (!tab_sil[rsp]) cd = 100;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        n_done++;
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected no done");
        end else begin
          e = q.pop_front();
          chk("is_square",   32'(is_square),   32'(e.sq));
          chk("vote_cnt",    32'(vote_cnt),    32'(e.vote));
          chk("width_min",   32'(width_min),   32'(e.wmin));
          chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
        end
      end
    end
  end

  task automatic set_tab(input logic [3:0] sq, input logic [WIDTH_W-1:0] w0, w1, w2, w3,
                         input logic [3:0] sil);
    tab_sq  = sq;
    tab_sil = sil;
    tab_w[0] = w0; tab_w[1] = w1; tab_w[2] = w2; tab_w[3] = w3;
  endtask

  task automatic trig_pulse(input string tag, input bit check);
    @(posedge clk); #1 trig = 1'b1;
    @(posedge clk); #1 trig = 1'b0;
    @(negedge clk);
    if (check) begin
      chk({tag, "_busy_after_trig"}, 32'(busy), 32'd1);
      chk({tag, "_start_after_trig"}, 32'(jif.jdg_start), 32'd1);
    end
  endtask

  task automatic wait_idle(input int bound, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", tag, bound);
    end
  endtask

  task automatic run(input exp_t e, input string tag);
    int s0 = n_start;
    int d0 = n_done;
    q.push_back(e);
    trig_pulse(tag, 1'b1);
    wait_idle(20000, tag);
    repeat (2) @(negedge clk);
    chk({tag, "_starts"}, 32'(n_start - s0), 32'd4);
    chk({tag, "_dones"}, 32'(n_done - d0), 32'd1);
  endtask

  initial begin : main
    int s0, d0;
    bit ok;
    set_tab(4'b0000, '0, '0, '0, '0, 4'b0000);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_is_square", 32'(is_square), 32'd0);
    chk("rst_vote_cnt", 32'(vote_cnt), 32'd0);
    chk("rst_width_min", 32'(width_min), 32'(W_NONE));
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_jdg_start", 32'(jif.jdg_start), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef SQJ_AUTO_RERUN_EN
    set_tab(4'b0111, 18'd500, 18'd420, 18'd450, 18'd600, 4'b0000);
    d0 = n_done;
    q.push_back('{sq: 1'b1, vote: 4'd3, wmin: 18'd420, tmo: 1'b0});
    q.push_back('{sq: 1'b1, vote: 4'd3, wmin: 18'd420, tmo: 1'b0});
    trig_pulse("auto", 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (n_done - d0 == 2) ok = 1'b1;
    end
    chk("auto_two_dones", 32'(ok), 32'd1);
    chk("auto_busy_between_runs", 32'(busy), 32'd1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("auto_abort_busy", 32'(busy), 32'd0);
    repeat (300) @(negedge clk);
    chk("auto_no_done_after_abort", 32'(n_done - d0), 32'd2);
`else
    // 1: three square votes, min width 420
    set_tab(4'b0111, 18'd500, 18'd420, 18'd450, 18'd600, 4'b0000);
    run('{sq: 1'b1, vote: 4'd3, wmin: 18'd420, tmo: 1'b0}, "t1");

    // 2: two votes, all-ones width skipped
    set_tab(4'b0011, 18'd300, W_NONE, 18'd250, 18'd280, 4'b0000);
    run('{sq: 1'b0, vote: 4'd2, wmin: 18'd250, tmo: 1'b0}, "t2");

    // 3: window 2 silent -> timeout, no vote, width untouched
    set_tab(4'b1111, 18'd500, 18'd100, 18'd450, 18'd600, 4'b0010);
    run('{sq: 1'b1, vote: 4'd3, wmin: 18'd450, tmo: 1'b1}, "t3");

    // 4: no valid widths at all
    set_tab(4'b0101, W_NONE, W_NONE, W_NONE, W_NONE, 4'b0000);
    run('{sq: 1'b0, vote: 4'd2, wmin: 18'h3FFFF, tmo: 1'b0}, "t4");

    // 5: full run, then abort in window-2 WAIT together with a dready
    set_tab(4'b0111, 18'd500, 18'd420, 18'd450, 18'd600, 4'b0000);
    run('{sq: 1'b1, vote: 4'd3, wmin: 18'd420, tmo: 1'b0}, "t5a");
    s0 = n_start;
    d0 = n_done;
    trig_pulse("t5b", 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (n_start - s0 == 2) ok = 1'b1;
    end
    chk("t5_reached_window2", 32'(ok), 32'd1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1 abort = 1'b1; inject_dready = 1'b1;
    @(posedge clk); #1 abort = 1'b0; inject_dready = 1'b0;
    @(negedge clk);
    chk("t5_abort_busy", 32'(busy), 32'd0);
    repeat (200) @(negedge clk);
    chk("t5_no_more_starts", 32'(n_start - s0), 32'd2);
    chk("t5_no_done", 32'(n_done - d0), 32'd0);
    chk("t5_vote_cnt_kept", 32'(vote_cnt), 32'd3);
    chk("t5_width_kept", 32'(width_min), 32'd420);
    chk("t5_timeout_err_kept", 32'(timeout_err), 32'd0);

    // 6: trig while busy is ignored
    set_tab(4'b0011, 18'd300, W_NONE, 18'd250, 18'd280, 4'b0000);
    s0 = n_start;
    d0 = n_done;
    q.push_back('{sq: 1'b0, vote: 4'd2, wmin: 18'd250, tmo: 1'b0});
    trig_pulse("t6", 1'b1);
    repeat (30) @(negedge clk);
    trig_pulse("t6_wait", 1'b0);
    repeat (150) @(negedge clk);
    trig_pulse("t6_later", 1'b0);
    wait_idle(20000, "t6");
    repeat (2) @(negedge clk);
    chk("t6_starts", 32'(n_start - s0), 32'd4);
    chk("t6_dones", 32'(n_done - d0), 32'd1);

    // trig and abort together in IDLE: stay idle
    s0 = n_start;
    @(posedge clk); #1 trig = 1'b1; abort = 1'b1;
    @(posedge clk); #1 trig = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("t6_trig_abort_busy", 32'(busy), 32'd0);
    chk("t6_trig_abort_start", 32'(jif.jdg_start), 32'd0);
    repeat (5) @(negedge clk);
    chk("t6_trig_abort_nostart", 32'(n_start - s0), 32'd0);
`endif

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
